// File: rtl/fifo_wr_arbiter.sv
// Write-port arbiter for the async FIFO: round-robin among N_REQ producers with a bounded burst,
// zero-latency combinational grant, stall on FIFO full, and a 16-bit accepted-write counter.
module fifo_wr_arbiter #(
    parameter int N_REQ   = 4,
    parameter int d_width = 8,
    parameter int BURST   = 4
) (
    input  logic                                  wr_clk,
    input  logic                                  reset,
    input  logic [N_REQ-1:0]                      req_i,
    input  logic [N_REQ*d_width-1:0]              req_data,
    input  logic                                  full_o,
    output logic [N_REQ-1:0]                      gnt_o,
    output logic                                  wr_en,
    output logic [d_width-1:0]                    wr_data,
    output logic [$clog2(N_REQ)-1:0]              owner_o,
    output logic                                  busy_o,
    output logic [15:0]                           wr_count_o
);
    localparam int OW = $clog2(N_REQ);
    localparam int CW = $clog2(BURST + 1);

    typedef enum logic {
        ST_IDLE,
        ST_BURST
    } state_t;

    state_t          state_q, state_d;
    logic [OW-1:0]   owner_q, owner_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [15:0]     wr_count_q, wr_count_d;

    logic [2*N_REQ-1:0] req_dbl;
    logic [N_REQ-1:0]   req_rot;
    logic               keep;
    logic               found;
    logic               grant;
    logic [OW:0]        off;
    logic [OW:0]        sum;
    logic [OW-1:0]      win;

    // Rotate the request vector so bit 0 is the requester just after the owner; owner lands last.
    assign req_dbl = {req_i, req_i};
    assign req_rot = req_dbl[{1'b0, owner_q} + (OW+1)'(1) +: N_REQ];

    always_comb begin
        keep  = (state_q == ST_BURST) && req_i[owner_q] && (cnt_q < CW'(BURST));
        found = 1'b0;
        off   = '0;
        for (int j = N_REQ - 1; j >= 0; j--) begin
            if (req_rot[j]) begin
                found = 1'b1;
                off   = (OW+1)'(j);
            end
        end
        sum = {1'b0, owner_q} + off + (OW+1)'(1);
        if (sum >= (OW+1)'(N_REQ)) begin
            sum = sum - (OW+1)'(N_REQ);
        end
        win = keep ? owner_q : sum[OW-1:0];
        // Reset suppresses the write port even though requests may be pending.
        grant = (keep || found) && !full_o && !reset;
    end

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_gnt
            assign gnt_o[gi] = grant && (win == OW'(gi));
        end
    endgenerate

    always_comb begin
        wr_data = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (gnt_o[k]) begin
                wr_data = wr_data | req_data[k*d_width +: d_width];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        cnt_d      = cnt_q;
        wr_count_d = wr_count_q;
        if (grant) begin
            if (keep) begin
                cnt_d = cnt_q + CW'(1);
            end else begin
                owner_d = win;
                cnt_d   = CW'(1);
            end
            state_d    = ST_BURST;
            wr_count_d = wr_count_q + 16'd1;
        end else if (req_i == '0) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge wr_clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            owner_q    <= OW'(N_REQ - 1);
            cnt_q      <= '0;
            wr_count_q <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            cnt_q      <= cnt_d;
            wr_count_q <= wr_count_d;
        end
    end

    assign wr_en      = grant;
    assign owner_o    = owner_q;
    assign busy_o     = (state_q == ST_BURST);
    assign wr_count_o = wr_count_q;
endmodule
